// File: rtl/dist_spi_reader_pkg.sv
// Shared types and defaults for the distribution-sample SPI reader.
package dist_spi_pkg;

  localparam int         DIST_W_DEF   = 256;
  localparam logic [7:0] CMD_READ_DEF = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_CMD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_CS_HOLD  = 3'd4
  } spi_state_e;

endpackage

// File: rtl/dist_spi_reader_clk_gen.sv
// SCLK generator: half_tick marks the end of every CLK_DIV-cycle half period;
// sclk toggles on those ticks only while the master is shifting bits.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic sclk_en,
  output logic half_tick,
  output logic sclk
);

  localparam int CW = $clog2(CLK_DIV) + 1;

  logic [CW-1:0] cnt_reg;

  assign half_tick = en && (cnt_reg == CW'(CLK_DIV - 1));

  // Half-period counter and SCLK level; clr restarts both at phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      sclk    <= 1'b0;
    end else if (clr) begin
      cnt_reg <= '0;
      sclk    <= 1'b0;
    end else if (en) begin
      if (half_tick) begin
        cnt_reg <= '0;
        if (sclk_en) sclk <= ~sclk;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dist_spi_reader.sv
// SPI mode-0 master fetching one DIST_W-bit distribution sample per start.
// Optional command phase: define DIST_SPI_CMD_EN to send CMD_READ before the
// payload; otherwise DATA follows CS_SETUP directly and MOSI stays low.
module dist_spi_reader
  import dist_spi_pkg::*;
#(
  parameter int         CLK_DIV  = 4,
  parameter int         DIST_W   = DIST_W_DEF,
  parameter logic [7:0] CMD_READ = CMD_READ_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic [DIST_W-1:0] dist_data,
  output logic              dist_valid,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int BCW = $clog2(DIST_W + 8) + 1;

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("dist_spi_reader: CLK_DIV must be at least 1");
  end

  spi_state_e        state_reg;
  logic [BCW-1:0]    bit_cnt_reg;
  logic [DIST_W-1:0] data_sr_reg;
  logic              half_tick;
  logic              sclk;
  logic              sclk_en;
  logic              sclk_rise;
  logic              sclk_fall;

`ifdef DIST_SPI_CMD_EN
  assign sclk_en = (state_reg == ST_CMD) || (state_reg == ST_DATA);
`else
  assign sclk_en = (state_reg == ST_DATA);
`endif

  // A tick with sclk low ends the low half (rising edge, sample MISO);
  // with sclk high it ends the bit cell (falling edge, next bit).
  assign sclk_rise = half_tick && sclk_en && !sclk;
  assign sclk_fall = half_tick && sclk_en && sclk;
  assign spi_sclk  = sclk;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_reg != ST_IDLE),
    .clr       ((state_reg == ST_IDLE) && start),
    .sclk_en   (sclk_en),
    .half_tick (half_tick),
    .sclk      (sclk)
  );

  // Transfer sequencing, payload capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      data_sr_reg <= '0;
      busy        <= 1'b0;
      spi_cs_n    <= 1'b1;
      dist_data   <= '0;
      dist_valid  <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg   <= ST_CS_SETUP;
            busy        <= 1'b1;
            spi_cs_n    <= 1'b0;
            bit_cnt_reg <= '0;
          end
        end
        ST_CS_SETUP: begin
          if (half_tick) begin
            bit_cnt_reg <= '0;
`ifdef DIST_SPI_CMD_EN
            state_reg   <= ST_CMD;
`else
            state_reg   <= ST_DATA;
`endif
          end
        end
`ifdef DIST_SPI_CMD_EN
        ST_CMD: begin
          if (sclk_fall) begin
            if (bit_cnt_reg == BCW'(7)) begin
              state_reg   <= ST_DATA;
              bit_cnt_reg <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BCW'(1);
            end
          end
        end
`endif
        ST_DATA: begin
          if (sclk_rise) begin
            data_sr_reg <= {data_sr_reg[DIST_W-2:0], spi_miso};
          end else if (sclk_fall) begin
            if (bit_cnt_reg == BCW'(DIST_W - 1)) begin
              state_reg <= ST_CS_HOLD;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BCW'(1);
            end
          end
        end
        ST_CS_HOLD: begin
          if (half_tick) begin
            state_reg  <= ST_IDLE;
            busy       <= 1'b0;
            spi_cs_n   <= 1'b1;
            dist_data  <= data_sr_reg;
            dist_valid <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef DIST_SPI_CMD_EN
  logic [7:0] cmd_sr_reg;
  logic       mosi_reg;

  // Command byte shifter: first bit out as CS_SETUP ends, the rest on
  // each falling edge, MOSI returns low once the command is done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_sr_reg <= '0;
      mosi_reg   <= 1'b0;
    end else if ((state_reg == ST_CS_SETUP) && half_tick) begin
      mosi_reg   <= CMD_READ[7];
      cmd_sr_reg <= {CMD_READ[6:0], 1'b0};
    end else if ((state_reg == ST_CMD) && sclk_fall) begin
      if (bit_cnt_reg == BCW'(7)) begin
        mosi_reg <= 1'b0;
      end else begin
        mosi_reg   <= cmd_sr_reg[7];
        cmd_sr_reg <= {cmd_sr_reg[6:0], 1'b0};
      end
    end
  end

  assign spi_mosi = mosi_reg;
`else
  // CMD_READ has no role without the command phase.
  logic unused_cmd_read;
  assign unused_cmd_read = ^CMD_READ;
  assign spi_mosi        = 1'b0;
`endif

endmodule

// File: tb/tb_dist_spi_reader.sv
// Scoreboard bench for dist_spi_reader with a cycle-level SPI slave model.
module tb_dist_spi_reader;

  localparam int DIV = 3;
  localparam int W   = 256;
`ifdef DIST_SPI_CMD_EN
  localparam int CMD_BITS = 8;
`else
  localparam int CMD_BITS = 0;
`endif
  localparam int N = W + CMD_BITS;
  localparam int T = DIV * (2 + 2 * N);
  localparam logic [7:0]   CMD  = 8'h03;
  localparam logic [W-1:0] PAT  = {4{64'h0123456789ABCDEF}};
  localparam logic [W-1:0] ALT  = {128{2'b10}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         spi_miso = 1'b0;
  logic         busy;
  logic [W-1:0] dist_data;
  logic         dist_valid;
  logic         spi_sclk;
  logic         spi_cs_n;
  logic         spi_mosi;

  dist_spi_reader #(
    .CLK_DIV  (DIV),
    .DIST_W   (W),
    .CMD_READ (CMD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .dist_data  (dist_data),
    .dist_valid (dist_valid),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    int           at;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] slave_q[$];
  int           checks = 0;
  int           failures = 0;
  int           hold_err = 0;
  int           mosi_err = 0;
  int           model_free_at = 0;
  int           rise_idx = 0;
  logic [W-1:0] exp_hold = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  // Pulse start for one cycle; the model accepts it only when idle.
  task automatic issue(input logic [W-1:0] p);
    int   e0;
    bit   acc;
    exp_t e;
    e0  = cyc + 1;
    acc = (e0 >= model_free_at);
    if (acc) begin
      e.data = p;
      e.at   = e0 + T;
      sb_q.push_back(e);
      slave_q.push_back(p);
      model_free_at = e0 + T + 1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (acc) chk("cs_n_after_start", spi_cs_n, 0);
  endtask

  // Hold start high while busy; the model retriggers on the first free edge.
  task automatic hold_start(input logic [W-1:0] p);
    int   e0;
    int   budget;
    exp_t e;
    e0     = model_free_at;
    e.data = p;
    e.at   = e0 + T;
    sb_q.push_back(e);
    slave_q.push_back(p);
    model_free_at = e0 + T + 1;
    start  = 1'b1;
    budget = 2 * T;
    while (cyc < e0 && budget > 0) begin
      tick();
      budget--;
    end
    start = 1'b0;
    chk("busy_after_retrigger", busy, 1);
    chk("cs_n_after_retrigger", spi_cs_n, 0);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 2 * T + 100;
    while (sb_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL timeout: %0d transfers outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: every dist_valid pops one expectation; otherwise data must hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dist_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: dist_valid=1 at cycle %0d, required no pulse", cyc);
          end else begin
            e = sb_q.pop_front();
            chk("dist_data", dist_data, e.data);
            chk("valid_cycle", cyc, e.at);
            chk("busy_at_done", busy, 0);
            chk("cs_n_at_done", spi_cs_n, 1);
            chk("sclk_rises", rise_idx, N);
            exp_hold = e.data;
          end
        end else if (dist_data !== exp_hold) begin
          hold_err++;
        end
      end
    end
  end

  // Slave: serves the payload MSB first after any command bits, checks MOSI
  // at every SCLK rise.
  initial begin
    logic         ps;
    logic         pc;
    logic [W-1:0] cur;
    logic [7:0]   cmd_byte;
    int           di;
    ps       = 1'b0;
    pc       = 1'b1;
    cur      = '0;
    cmd_byte = CMD;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ps       = 1'b0;
        pc       = 1'b1;
        rise_idx = 0;
        spi_miso = 1'b0;
      end else begin
        if (pc && !spi_cs_n) begin
          rise_idx = 0;
          cur = (slave_q.size() != 0) ? slave_q.pop_front() : '0;
        end
        if (!ps && spi_sclk) begin
          if (rise_idx < CMD_BITS) begin
            if (spi_mosi !== cmd_byte[7 - rise_idx]) mosi_err++;
          end else if (spi_mosi !== 1'b0) begin
            mosi_err++;
          end
          rise_idx++;
        end
`ifndef DIST_SPI_CMD_EN
        if (spi_mosi !== 1'b0) mosi_err++;
`endif
        di = rise_idx - CMD_BITS;
        spi_miso = (!spi_cs_n && di >= 0 && di < W) ? cur[W-1-di] : 1'b0;
        ps = spi_sclk;
        pc = spi_cs_n;
      end
    end
  end

  initial begin
    int budget;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (50) tick();
    chk("idle_cs_n", spi_cs_n, 1);
    chk("idle_sclk", spi_sclk, 0);
    chk("idle_busy", busy, 0);
    chk("idle_data", dist_data, 0);
    chk("idle_mosi", spi_mosi, 0);

    issue(PAT);
    wait_idle();
    issue(ALT);
    wait_idle();

    // Back-to-back random samples with small random gaps (including none).
    for (int i = 0; i < 3; i++) begin
      issue(rand_word());
      wait_idle();
      repeat ($urandom_range(0, 4)) tick();
    end

    // Mid-transfer pulse is dropped; start held high retriggers at once.
    issue(rand_word());
    repeat (T / 2) tick();
    issue(rand_word());
    repeat (T / 4) tick();
    hold_start(rand_word());
    wait_idle();

    // Reset during data bit 100 aborts without a completion pulse.
    issue(rand_word());
    budget = 2 * T;
    while (rise_idx != CMD_BITS + 100 && budget > 0) begin
      tick();
      budget--;
    end
    chk("reached_bit_100", rise_idx, CMD_BITS + 100);
    rst_n = 1'b0;
    #1;
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_data", dist_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", dist_valid, 0);
    sb_q.delete();
    exp_hold      = '0;
    model_free_at = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    issue(rand_word());
    wait_idle();

    repeat (5) tick();
    chk("mosi_pattern_errors", mosi_err, 0);
    chk("data_hold_errors", hold_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
